// File: rtl/bit_reorder_pipe.sv
// Multi-channel bit/byte/channel reorder stage feeding a 2-entry skid buffer.
// Optional output-transfer counter is enabled with `define BIT_REORDER_COUNT_EN.
module bit_reorder_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef BIT_REORDER_COUNT_EN
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [15:0]               xfer_count
`else
  output logic [CHANNELS*WIDTH-1:0] out_data
`endif
);

  localparam int unsigned DataW  = CHANNELS * WIDTH;
  localparam int unsigned NBytes = WIDTH / 8;
  localparam bit          ByteOk = (WIDTH % 8) == 0;

  logic [DataW-1:0] reord;
  logic [DataW-1:0] mem_q [2];
  logic [1:0]       cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr;
  logic             push, pop;

  always_comb begin
    reord = in_data;
    case (in_mode)
      2'd0: reord = in_data;
      2'd1: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          for (int unsigned k = 0; k < WIDTH; k++) begin
            reord[c*WIDTH + WIDTH-1-k] = in_data[c*WIDTH + k];
          end
        end
      end
      2'd2: begin
        // Widths that are not a whole number of bytes fall back to bit reversal.
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (ByteOk) begin
            for (int unsigned b = 0; b < NBytes; b++) begin
              reord[c*WIDTH + (NBytes-1-b)*8 +: 8] = in_data[c*WIDTH + b*8 +: 8];
            end
          end else begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
              reord[c*WIDTH + WIDTH-1-k] = in_data[c*WIDTH + k];
            end
          end
        end
      end
      2'd3: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          reord[c*WIDTH +: WIDTH] = in_data[(CHANNELS-1-c)*WIDTH +: WIDTH];
        end
      end
    endcase
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Write slot is the one after the head when occupied, the head itself when empty.
  assign wr_ptr    = rd_ptr_q ^ cnt_q[0];

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        mem_q[wr_ptr] <= reord;
      end
    end
  end

`ifdef BIT_REORDER_COUNT_EN
  logic [15:0] xfer_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= 16'd0;
    end else if (pop) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule
